// File: rtl/div_arbiter_if.sv
// Bundle of requester, divider-side and response signals for div_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface div_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_dividend;
  logic [NREQ*WIDTH-1:0] req_divisor;
  logic [NREQ-1:0]       req_ready;
  logic                  div_start;
  logic [WIDTH-1:0]      div_dividend;
  logic [WIDTH-1:0]      div_divisor;
  logic                  div_ready;
  logic [WIDTH-1:0]      div_quotient;
  logic [WIDTH-1:0]      div_remainder;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_quotient;
  logic [WIDTH-1:0]      rsp_remainder;
  logic                  rsp_err;
  logic                  busy;

  modport slave (
    input  req_valid, req_dividend, req_divisor, div_ready, div_quotient,
           div_remainder, rsp_ready,
    output req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_id,
           rsp_quotient, rsp_remainder, rsp_err, busy
  );

  modport master (
    output req_valid, req_dividend, req_divisor, div_ready, div_quotient,
           div_remainder, rsp_ready,
    input  req_ready, div_start, div_dividend, div_divisor, rsp_valid, rsp_id,
           rsp_quotient, rsp_remainder, rsp_err, busy
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one serial restoring divider among NREQ requesters.
// Define DIV_ARB_ZERO_CHECK_EN to answer divide-by-zero directly with rsp_err set.
module div_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input logic          clk,
  input logic          reset,
  div_arbiter_if.slave bus
);
  localparam int unsigned NR = NREQ;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic             r_start;
  logic             r_rsp_valid;
  logic             r_busy;
`ifdef DIV_ARB_ZERO_CHECK_EN
  logic             r_err;
`endif

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDW:0]      w_sum;
  logic              w_any;
  logic [IDW-1:0]    w_win;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [NREQ-1:0]   w_grant;
  logic [WIDTH-1:0]  w_opa;
  logic [WIDTH-1:0]  w_opb;

  // Rotate so bit k is requester (ptr+k) mod NREQ; first set bit wins.
  assign w_dbl = {bus.req_valid, bus.req_valid};
  assign w_rot = NREQ'(w_dbl >> r_ptr);

  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_sum = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!w_any && w_rot[k]) begin
        w_any = 1'b1;
        w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NR)) w_sum = w_sum - (IDW+1)'(NR);
        w_win = w_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    w_opa = '0;
    w_opb = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (w_win == IDW'(i)) begin
        w_opa = bus.req_dividend[i*WIDTH +: WIDTH];
        w_opb = bus.req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_win == IDW'(NR - 1)) ? '0 : w_win + 1'b1;
  assign w_grant   = (w_any && r_state == S_IDLE && !reset) ? (NREQ'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef DIV_ARB_ZERO_CHECK_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id       <= w_win;
            r_dividend <= w_opa;
            r_divisor  <= w_opb;
            r_ptr      <= w_ptr_nxt;
            r_busy     <= 1'b1;
            r_state    <= S_ISSUE;
`ifdef DIV_ARB_ZERO_CHECK_EN
            // Start is registered, so the zero test is made on the accept edge.
            r_start    <= (w_opb != '0);
`else
            r_start    <= 1'b1;
`endif
          end
        end
        S_ISSUE: begin
          r_start <= 1'b0;
`ifdef DIV_ARB_ZERO_CHECK_EN
          if (r_divisor == '0) begin
            r_quot      <= '1;
            r_rem       <= r_dividend;
            r_err       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_state <= S_SETTLE;
          end
`else
          r_state <= S_SETTLE;
`endif
        end
        S_SETTLE: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.div_ready) begin
            r_quot      <= bus.div_quotient;
            r_rem       <= bus.div_remainder;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef DIV_ARB_ZERO_CHECK_EN
            r_err       <= 1'b0;
`endif
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = w_grant;
  assign bus.div_start     = r_start;
  assign bus.div_dividend  = r_dividend;
  assign bus.div_divisor   = r_divisor;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_id;
  assign bus.rsp_quotient  = r_quot;
  assign bus.rsp_remainder = r_rem;
  assign bus.busy          = r_busy;
`ifdef DIV_ARB_ZERO_CHECK_EN
  assign bus.rsp_err       = r_err;
`else
  assign bus.rsp_err       = 1'b0;
`endif
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: serial divider model, round-robin reference and response scoreboard.
module tb_div_arbiter;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int IDW = 2;
`ifdef DIV_ARB_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic d_rst = 1'b1;
  always #5 clk = ~clk;

  div_arbiter_if #(.WIDTH(W), .NREQ(N), .IDW(IDW)) bus ();
  div_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Shared serial restoring divider: one quotient bit per cycle, divisor sampled every step.
  logic [4:0]   d_cnt;
  logic [W-1:0] d_q, d_r;

  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] r, input logic [W-1:0] q,
                                               input logic [W-1:0] d);
    logic [W:0] p;
    p = {r, q[W-1]};
    if (p >= {1'b0, d}) return {W'(p - {1'b0, d}), q[W-2:0], 1'b1};
    return {p[W-1:0], q[W-2:0], 1'b0};
  endfunction

  always @(posedge clk) begin
    if (d_rst) begin
      d_cnt <= '0;
      d_q   <= '0;
      d_r   <= '0;
    end else if (bus.div_start) begin
      d_cnt <= 5'(W);
      d_q   <= bus.div_dividend;
      d_r   <= '0;
    end else if (d_cnt != 0) begin
      {d_r, d_q} <= div_step(d_r, d_q, bus.div_divisor);
      d_cnt      <= d_cnt - 5'd1;
    end
  end
  assign bus.div_ready     = (d_cnt == 0);
  assign bus.div_quotient  = d_q;
  assign bus.div_remainder = d_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           err;
    int             acc;
    int             lat;
  } exp_t;

  exp_t              sb[$];
  bit                outstanding = 1'b0;
  int                m_ptr       = 0;
  bit                rsp_seen    = 1'b0;
  bit                start_next  = 1'b0;
  bit                track       = 1'b0;
  logic [2*W+IDW:0]  snap;
  logic [N-1:0]      accepted    = '0;
  int                grant_q[$];
  int                rise_q[$];

  task automatic monitor_step();
    int               win;
    logic [N-1:0]     exp_rdy;
    logic [W-1:0]     a, b;
    exp_t             e;
    logic [2*W+IDW:0] cur;
    if (reset) begin
      sb.delete();
      outstanding = 1'b0;
      m_ptr       = 0;
      rsp_seen    = 1'b0;
      start_next  = 1'b0;
      accepted    = '0;
      return;
    end
    chk("busy", bus.busy, outstanding);
    if (bus.div_start || start_next) chk("div_start", bus.div_start, start_next);
    start_next = 1'b0;

    win = -1;
    if (!outstanding)
      for (int k = 0; k < N; k++)
        if (win < 0 && ((bus.req_valid >> ((m_ptr + k) % N)) & 1) != 0) win = (m_ptr + k) % N;
    exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
    if (bus.req_valid != 0 || bus.req_ready != 0) chk("req_ready", bus.req_ready, exp_rdy);
    accepted = bus.req_valid & bus.req_ready;
    if (win >= 0 && accepted == exp_rdy) begin
      a     = W'(bus.req_dividend >> (win * W));
      b     = W'(bus.req_divisor >> (win * W));
      e.id  = IDW'(win);
      e.q   = (b == 0) ? '1 : a / b;
      e.r   = (b == 0) ? a : a % b;
      e.err = ZC && (b == 0);
      e.acc = cyc;
      e.lat = (ZC && b == 0) ? 2 : W + 3;
      sb.push_back(e);
      outstanding = 1'b1;
      m_ptr       = (win + 1) % N;
      start_next  = !(ZC && b == 0);
      if (track) grant_q.push_back(win);
    end

    if (bus.rsp_valid) begin
      cur = {bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_err};
      if (!rsp_seen) begin
        chk("rsp_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
        rsp_seen = 1'b1;
        snap     = cur;
        if (track) rise_q.push_back(cyc);
      end else begin
        chk("rsp_stable", cur, snap);
      end
      if (bus.rsp_ready) begin
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_quotient", bus.rsp_quotient, e.q);
          chk("rsp_remainder", bus.rsp_remainder, e.r);
          chk("rsp_err", bus.rsp_err, e.err);
        end
        rsp_seen    = 1'b0;
        outstanding = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  bit keep_valid = 1'b0;
  bit rand_mode  = 1'b0;
  bit hold_ready = 1'b1;

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N*W-1:0] m;
    m = (N*W)'({W{1'b1}}) << (i * W);
    bus.req_dividend = (bus.req_dividend & ~m) | ((N*W)'(a) << (i * W));
    bus.req_divisor  = (bus.req_divisor & ~m) | ((N*W)'(b) << (i * W));
    bus.req_valid    = bus.req_valid | (N'(1) << i);
  endtask

  task automatic drop_req(input int i);
    bus.req_valid = bus.req_valid & ~(N'(1) << i);
  endtask

  function automatic logic [W-1:0] rnd_b();
    case ($urandom_range(5))
      0:       return '0;
      1:       return W'(1);
      2:       return W'($urandom_range(20, 2));
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (((accepted >> i) & 1) != 0 && !keep_valid) drop_req(i);
    if (rand_mode) begin
      for (int i = 0; i < N; i++) begin
        if (((bus.req_valid >> i) & 1) == 0) begin
          if ($urandom_range(3) == 0) set_req(i, W'($urandom), rnd_b());
        end else if ($urandom_range(15) == 0) begin
          drop_req(i);
        end
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
    end else begin
      bus.rsp_ready = hold_ready;
    end
  endtask

  task automatic wait_quiet(input string nm, input int budget);
    int n = 0;
    while ((bus.req_valid != 0 || outstanding || bus.busy || bus.rsp_valid) && n < budget) begin
      tick();
      n++;
    end
    chk(nm, n < budget, 1'b1);
  endtask

  task automatic check_zero();
    chk("rst_ctl", {bus.req_ready, bus.div_start, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.busy}, '0);
    chk("rst_div_ops", {bus.div_dividend, bus.div_divisor}, '0);
    chk("rst_rsp_data", {bus.rsp_quotient, bus.rsp_remainder}, '0);
  endtask

  int           t_id[5] = '{2, 0, 1, 2, 0};
  logic [W-1:0] t_a[5]  = '{16'd100, 16'hFFFF, 16'd5, 16'h8000, 16'hFFFF};
  logic [W-1:0] t_b[5]  = '{16'd7, 16'd1, 16'd9, 16'h8000, 16'hFFFF};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.rsp_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    d_rst = 1'b0;
    @(negedge clk);
    check_zero();

    // Every requester always pending: strict rotation, one slot per WIDTH+4 cycles.
    track      = 1'b1;
    keep_valid = 1'b1;
    tick();
    for (int i = 0; i < N; i++) set_req(i, 16'd11, 16'd3);
    n = 0;
    while (grant_q.size() < 5 && n < 200) begin
      tick();
      n++;
    end
    chk("rr_grants_seen", grant_q.size() >= 5, 1'b1);
    keep_valid    = 1'b0;
    bus.req_valid = '0;
    wait_quiet("rr_drain", 200);
    track = 1'b0;
    for (int k = 0; k < grant_q.size() && k < 5; k++) chk("rr_order", grant_q[k], k % N);
    chk("rr_rsp_count", rise_q.size(), 5);
    for (int k = 1; k < rise_q.size(); k++) chk("rr_spacing", rise_q[k] - rise_q[k-1], W + 4);

    for (int k = 0; k < 5; k++) begin
      set_req(t_id[k], t_a[k], t_b[k]);
      wait_quiet("op_drain", 100);
    end

    // Backpressure held in DONE while another requester waits.
    hold_ready    = 1'b0;
    bus.rsp_ready = 1'b0;
    set_req(0, 16'd1234, 16'd56);
    set_req(3, 16'd999, 16'd10);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bp_rsp_seen", bus.rsp_valid, 1'b1);
    repeat (10) tick();
    chk("bp_hold", bus.rsp_valid, 1'b1);
    hold_ready    = 1'b1;
    bus.rsp_ready = 1'b1;
    wait_quiet("bp_drain", 200);

    // Reset while the divider is mid-iteration.
    set_req(2, 16'd5000, 16'd3);
    n = 0;
    while (!bus.busy && n < 10) begin
      tick();
      n++;
    end
    repeat (8) tick();
    chk("pre_reset_busy", bus.busy, 1'b1);
    bus.req_valid = '0;
    reset         = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_zero();
    tick();
    track = 1'b1;
    grant_q.delete();
    set_req(3, 16'd700, 16'd9);
    set_req(1, 16'd1000, 16'd13);
    wait_quiet("post_reset_drain", 200);
    track = 1'b0;
    chk("post_reset_first", (grant_q.size() > 0) ? grant_q[0] : -1, 1);

    set_req(3, 16'd42, 16'd0);
    wait_quiet("zero_drain", 100);

    rand_mode = 1'b1;
    repeat (1500) tick();
    rand_mode  = 1'b0;
    hold_ready = 1'b1;
    wait_quiet("rand_drain", 400);
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
